// File: rtl/alu_share_arbiter.sv
// Shares the execute-stage ALU between REQ0 (integer ops) and REQ1 (address generation).
// Arbitrates, drives the ALU for one cycle, registers the result and returns it with source and tag.
module alu_share_arbiter #(
    parameter int unsigned W          = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_WAIT   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_data0,
    input  logic [W-1:0]     req0_data1,
    input  logic [2:0]       req0_funct3,
    input  logic             req0_funct1,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_data0,
    input  logic [W-1:0]     req1_data1,
    input  logic [2:0]       req1_funct3,
    input  logic             req1_funct1,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             alu_en,
    output logic [W-1:0]     alu_data0,
    output logic [W-1:0]     alu_data1,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct1,
    input  logic [W-1:0]     alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [W-1:0]     rsp_result,
    output logic             busy
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                can_accept_c;
    logic                grant1_c;
    logic                fire_c;
    logic                last_grant_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                op_src_q;
    logic [TAG_W-1:0]    op_tag_q;

    // Grant selection; READY is combinational so a request can be taken in the same cycle
    always_comb begin
        can_accept_c = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        grant1_c     = req1_valid;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0) begin
                grant1_c = (wait_q == WAIT_W'(MAX_WAIT));
            end else begin
                grant1_c = !last_grant_q;
            end
        end
        req0_ready = rst_n && can_accept_c && req0_valid && !grant1_c;
        req1_ready = rst_n && can_accept_c && req1_valid && grant1_c;
        fire_c     = req0_ready || req1_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> (IDLE | EXEC)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fire_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = fire_c ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arbitration history: round-robin pointer and REQ1 starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            wait_q       <= '0;
        end else if (fire_c) begin
            last_grant_q <= grant1_c;
            if (grant1_c) begin
                wait_q <= '0;
            end else if (req1_valid && (wait_q != WAIT_W'(MAX_WAIT))) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    // Operand capture into the ALU bus registers, result capture into the response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en     <= 1'b0;
            alu_data0  <= '0;
            alu_data1  <= '0;
            alu_funct3 <= '0;
            alu_funct1 <= 1'b0;
            op_src_q   <= 1'b0;
            op_tag_q   <= '0;
            rsp_valid  <= 1'b0;
            rsp_src    <= 1'b0;
            rsp_tag    <= '0;
            rsp_result <= '0;
            busy       <= 1'b0;
        end else begin
            if (fire_c) begin
                alu_en     <= 1'b1;
                alu_data0  <= grant1_c ? req1_data0  : req0_data0;
                alu_data1  <= grant1_c ? req1_data1  : req0_data1;
                alu_funct3 <= grant1_c ? req1_funct3 : req0_funct3;
                alu_funct1 <= grant1_c ? req1_funct1 : req0_funct1;
                op_tag_q   <= grant1_c ? req1_tag    : req0_tag;
                op_src_q   <= grant1_c;
            end else if (state_q == EXEC) begin
                alu_en     <= 1'b0;
                alu_data0  <= '0;
                alu_data1  <= '0;
                alu_funct3 <= '0;
                alu_funct1 <= 1'b0;
            end

            if (state_q == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_tag    <= op_tag_q;
                rsp_src    <= op_src_q;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
                rsp_result <= '0;
                rsp_tag    <= '0;
                rsp_src    <= 1'b0;
            end

            busy <= (state_d != IDLE);
        end
    end

    // Requesters must hold VALID and payload stable until accepted
    a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req0_valid && !req0_ready) |=> (req0_valid &&
            $stable({req0_data0, req0_data1, req0_funct3, req0_funct1, req0_tag})));

    a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req1_valid && !req1_ready) |=> (req1_valid &&
            $stable({req1_data0, req1_data1, req1_funct3, req1_funct1, req1_tag})));

    a_one_ready: assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule
